// File: rtl/ltl_nfa_engine.sv
// Programmable NFA engine for runtime LTL monitoring: STEs, edges and masks are loaded through cfg_*, one symbol per handshake, reports queued in a FIFO.
// Optional feature macro LTL_NFA_SYM_IDX_EN: carries a symbol index with every report; when undefined rpt_idx is tied to 0.

module ltl_nfa_engine #(
   parameter int NUM_STE    = 16,
   parameter int SYM_W      = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [SYM_W+1:0]   cfg_addr,
   input  logic [31:0]        cfg_wdata,
   output logic               cfg_err,
   input  logic               start,
   input  logic               stop,
   output logic               busy,
   output logic               done,
   input  logic               sym_valid,
   output logic               sym_ready,
   input  logic [SYM_W-1:0]   sym_data,
   output logic               rpt_valid,
   input  logic               rpt_ready,
   output logic [NUM_STE-1:0] rpt_vec,
   output logic [CNT_W-1:0]   rpt_idx,
   output logic [NUM_STE-1:0] active
);

   localparam int WORD_W = SYM_W - 5;
   localparam int WORDS  = 1 << WORD_W;
   localparam int STE_IW = (NUM_STE > 1) ? $clog2(NUM_STE) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

   state_t               state, state_next;
   logic [1:0]           cfg_type;
   logic [4:0]           cfg_ste;
   logic [STE_IW-1:0]    cfg_ste_idx;
   logic [WORD_W-1:0]    cfg_word;
   logic                 ste_ok, cfg_ok, cfg_bad;
   logic                 start_go, accept, push, pop, first;
   logic                 fifo_empty, fifo_full;
   logic [NUM_STE-1:0]   match_bit, enable, active_next;
   logic [31:0]          match_mem [NUM_STE][WORDS];
   logic [NUM_STE-1:0]   edge_row [NUM_STE];
   logic [NUM_STE-1:0]   sod_mask, all_mask, report_mask;
   logic [NUM_STE-1:0]   fifo_vec [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [PTR_W:0]       count;

   assign cfg_type    = cfg_addr[SYM_W+1:SYM_W];
   assign cfg_ste     = cfg_addr[SYM_W-1:SYM_W-5];
   assign cfg_ste_idx = cfg_ste[STE_IW-1:0];
   assign cfg_word    = cfg_addr[WORD_W-1:0];

   // Type 2 only has three targets (sod, all, report); type 3 is a harmless no-op.
   always_comb begin
      ste_ok = 1'b0;
      case (cfg_type)
         2'd0, 2'd1: ste_ok = (int'(cfg_ste) < NUM_STE);
         2'd2:       ste_ok = (cfg_ste <= 5'd2);
         default:    ste_ok = 1'b1;
      endcase
   end

   assign cfg_ok   = cfg_we && (state == S_IDLE) && ste_ok;
   assign cfg_bad  = cfg_we && !cfg_ok;
   assign start_go = start && (state == S_IDLE);
   assign accept   = sym_valid && sym_ready;
   assign push     = accept && |(active_next & report_mask);
   assign pop      = rpt_valid && rpt_ready;

   // NOTE: configuration RAM has no reset on purpose; a reset must not wipe a loaded program.
   always_ff @(posedge clk) begin
      if (cfg_ok) begin
         case (cfg_type)
            2'd0: match_mem[cfg_ste_idx][cfg_word] <= cfg_wdata;
            2'd1: edge_row[cfg_ste_idx] <= cfg_wdata[NUM_STE-1:0];
            2'd2: begin
               case (cfg_ste[1:0])
                  2'd0:    sod_mask    <= cfg_wdata[NUM_STE-1:0];
                  2'd1:    all_mask    <= cfg_wdata[NUM_STE-1:0];
                  2'd2:    report_mask <= cfg_wdata[NUM_STE-1:0];
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      match_bit = '0;
      for (int i = 0; i < NUM_STE; i++)
         match_bit[i] = match_mem[i][sym_data[SYM_W-1:5]][sym_data[4:0]];
   end

   // enable_i ORs edge column i against the active vector.
   always_comb begin
      enable = all_mask | (sod_mask & {NUM_STE{first}});
      for (int i = 0; i < NUM_STE; i++)
         for (int k = 0; k < NUM_STE; k++)
            enable[i] = enable[i] | (active[k] & edge_row[k][i]);
      active_next = enable & match_bit;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start)      state_next = S_RUN;
         S_RUN:   if (stop)       state_next = S_DRAIN;
         S_DRAIN: if (fifo_empty) state_next = S_IDLE;
         default:                 state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != S_IDLE);
      done      = (state == S_DRAIN) && fifo_empty;
      sym_ready = (state == S_RUN) && !fifo_full;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active  <= '0;
         first   <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         if (start_go) begin
            active <= '0;
            first  <= 1'b1;
         end else if (accept) begin
            active <= active_next;
            first  <= 1'b0;
         end
         if (cfg_bad)       cfg_err <= 1'b1;
         else if (start_go) cfg_err <= 1'b0;
      end
   end

`ifdef LTL_NFA_SYM_IDX_EN
   logic [CNT_W-1:0] sym_idx;
   logic [CNT_W-1:0] fifo_idx [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (reset)         sym_idx <= '0;
      else if (start_go) sym_idx <= '0;
      else if (accept)   sym_idx <= sym_idx + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (push) fifo_idx[wr_ptr] <= sym_idx;
   end

   assign rpt_idx = fifo_idx[rd_ptr];
`else
   assign rpt_idx = '0;
`endif

   always_ff @(posedge clk) begin
      if (push) fifo_vec[wr_ptr] <= active_next;
   end

   // Push never happens when full because sym_ready is already low.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: ;
         endcase
      end
   end

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign rpt_valid  = !fifo_empty;
   assign rpt_vec    = fifo_vec[rd_ptr];

endmodule
